change_dispenser: RTL
=====================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter AMT_W, default 6: width of cost/paid/remaining in nickel units; legal range 3 to 8.
REQ-002 Parameter CNT_W, default 4: width of each coin inventory counter.
REQ-003 Parameters INIT_Q / INIT_D / INIT_N, default 2 / 2 / 3: reset inventory of quarters / dimes / nickels.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset_L  in  1  synchronous, active-low reset.
REQ-006 start  in  1  request a transaction; sampled only in IDLE.
REQ-007 cost, paid  in  AMT_W each  price and tendered amount in nickels; sampled with start.
REQ-008 busy  out  1  high in every state other than IDLE.
REQ-009 done  out  1  single-cycle pulse ending a transaction.
REQ-010 exact_amount, cough_up_more, short_change  out  1 each  result flags; held from done until the next accepted start.
REQ-011 coin_valid  out  1  one coin is issued in this cycle.
REQ-012 coin  out  3  coin value: 5 = quarter, 2 = dime, 1 = nickel; 0 when coin_valid is low.
REQ-013 remaining  out  AMT_W  change still owed.
REQ-014 q_cnt, d_cnt, n_cnt  out  CNT_W each  current inventory.

Function
REQ-015 The FSM SHALL have three states: IDLE, DISPENSE, DONE.
REQ-016 IDLE: start=1 latches cost/paid; paid<cost -> DONE with cough_up_more=1; paid==cost -> DONE with exact_amount=1; paid>cost -> DISPENSE with remaining=paid-cost.
REQ-017 DISPENSE: each cycle, coin SHALL be the largest value v in {5,2,1} with v<=remaining and count>0.
REQ-018 When such a coin exists: coin_valid=1 combinationally that cycle; the count decrements by 1 and remaining decreases by v at the closing edge.
REQ-019 Transition to DONE when the post-update remaining==0; no coin is issued once remaining is 0.
REQ-020 When no eligible coin exists with remaining>0: coin_valid=0, short_change=1, go to DONE with remaining held at the owed value.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; flags and remaining hold.
REQ-022 start while busy SHALL be ignored with no side effect.
REQ-023 A counter SHALL never decrement below 0 or wrap.
REQ-024 Subtraction SHALL be in AMT_W bits; remaining is computed only when paid>cost, so it never underflows.
REQ-025 Latency: a transaction issuing N coins SHALL pulse done N+1 cycles after the start edge; exact, underpaid or empty-inventory cases pulse done 1 cycle after.

Reset
REQ-026 reset_L=0 at a clock edge SHALL force IDLE, busy=0, done=0, all flags 0, remaining=0, coin_valid=0, and q/d/n_cnt=INIT_Q/INIT_D/INIT_N.
REQ-027 Reset mid-DISPENSE SHALL abandon the transaction; coins already issued are not restored.

Configuration
REQ-028 Macro CHANGE_RELOAD_EN defined: add inputs reload (1 bit) and q_add/d_add/n_add (CNT_W bits each).
REQ-029 With the macro: reload=1 in IDLE adds each *_add to its counter, saturating at 2^CNT_W-1.
REQ-030 With the macro: reload is ignored while busy; with start and reload both high in IDLE, start wins and reload is dropped.
REQ-031 Macro undefined: no reload ports exist; inventory changes only by reset and dispensing.

Verification
REQ-032 Defaults, cost=8, paid=16: coins 5, 2, 1 on cycles 1-3, done on cycle 4, remaining=0, q/d/n_cnt=1/1/2.
REQ-033 cost=10, paid=10: done on cycle 1, exact_amount=1, coin_valid never asserted.
REQ-034 cost=10, paid=5: done on cycle 1, cough_up_more=1, inventory unchanged.
REQ-035 Inventory Q=0/D=0/N=1, change 3: one nickel issued, then short_change=1, remaining=2, done.
REQ-036 reset_L=0 during the second coin of REQ-032, then start held high while busy: IDLE, counts back to INIT, and the held start is accepted only once IDLE is reached.
REQ-037 CHANGE_RELOAD_EN defined, CNT_W=4, q_cnt=14, reload with q_add=5: q_cnt=15; the same reload while busy leaves q_cnt unchanged.

Source files
------------

// File: rtl/change_dispenser_if.sv
// change_dispenser_if
// Transaction, result and inventory signals of the change dispenser.
// The reload inputs exist only when CHANGE_RELOAD_EN is defined.
interface change_dispenser_if #(
    parameter int AMT_W = 6,
    parameter int CNT_W = 4
);
    logic             start;
    logic [AMT_W-1:0] cost;
    logic [AMT_W-1:0] paid;
`ifdef CHANGE_RELOAD_EN
    logic             reload;
    logic [CNT_W-1:0] q_add;
    logic [CNT_W-1:0] d_add;
    logic [CNT_W-1:0] n_add;
`endif
    logic             busy;
    logic             done;
    logic             exact_amount;
    logic             cough_up_more;
    logic             short_change;
    logic             coin_valid;
    logic [2:0]       coin;
    logic [AMT_W-1:0] remaining;
    logic [CNT_W-1:0] q_cnt;
    logic [CNT_W-1:0] d_cnt;
    logic [CNT_W-1:0] n_cnt;

    // Requester side: issues transactions and observes results.
    modport master (
        output start, cost, paid,
`ifdef CHANGE_RELOAD_EN
        output reload, q_add, d_add, n_add,
`endif
        input  busy, done, exact_amount, cough_up_more, short_change,
        input  coin_valid, coin, remaining, q_cnt, d_cnt, n_cnt
    );

    // Dispenser side.
    modport slave (
        input  start, cost, paid,
`ifdef CHANGE_RELOAD_EN
        input  reload, q_add, d_add, n_add,
`endif
        output busy, done, exact_amount, cough_up_more, short_change,
        output coin_valid, coin, remaining, q_cnt, d_cnt, n_cnt
    );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser
// Greedy coin change dispenser working in nickel units. A transaction
// latches cost/paid, then issues at most one coin per cycle (quarter=5,
// dime=2, nickel=1), always the largest coin that fits the amount still
// owed and is in stock. Results are flagged and held until the next
// accepted start.
// Optional feature: define CHANGE_RELOAD_EN to add inventory reload inputs
// (reload, q_add, d_add, n_add), applied in IDLE with saturation.
module change_dispenser #(
    parameter int AMT_W  = 6,
    parameter int CNT_W  = 4,
    parameter int INIT_Q = 2,
    parameter int INIT_D = 2,
    parameter int INIT_N = 3
) (
    input  logic               clock,
    input  logic               reset_L,
    change_dispenser_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DONE     = 2'd2
    } state_t;

    localparam logic [2:0] COIN_Q    = 3'd5;
    localparam logic [2:0] COIN_D    = 3'd2;
    localparam logic [2:0] COIN_N    = 3'd1;
    localparam logic [2:0] COIN_NONE = 3'd0;

    state_t           state_r, state_s;
    logic [AMT_W-1:0] remaining_r, remaining_s;
    logic             exact_r, exact_s;
    logic             cough_r, cough_s;
    logic             short_r, short_s;
    logic [CNT_W-1:0] q_r, q_s;
    logic [CNT_W-1:0] d_r, d_s;
    logic [CNT_W-1:0] n_r, n_s;
    logic             coin_valid_s;
    logic [2:0]       coin_s;
    logic [AMT_W-1:0] change_s;
    logic [2:0]       idle_pick_s;
    logic [2:0]       disp_pick_s;

    // Largest coin not exceeding the owed amount that is still in stock;
    // COIN_NONE when nothing can be issued.
    function automatic logic [2:0] pick_coin(
        input logic [AMT_W-1:0] owed,
        input logic [CNT_W-1:0] q,
        input logic [CNT_W-1:0] d,
        input logic [CNT_W-1:0] n
    );
        logic [2:0] res;
        if ((owed >= AMT_W'(5)) && (q != '0)) begin
            res = COIN_Q;
        end else if ((owed >= AMT_W'(2)) && (d != '0)) begin
            res = COIN_D;
        end else if ((owed >= AMT_W'(1)) && (n != '0)) begin
            res = COIN_N;
        end else begin
            res = COIN_NONE;
        end
        return res;
    endfunction

`ifdef CHANGE_RELOAD_EN
    // Counter addition that clamps at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction
`endif

    // Change is only meaningful when paid > cost; the IDLE branch guards it.
    assign change_s    = bus.paid - bus.cost;
    assign idle_pick_s = pick_coin(change_s, q_r, d_r, n_r);
    assign disp_pick_s = pick_coin(remaining_r, q_r, d_r, n_r);

    // Next-state, coin issue and inventory update logic.
    always_comb begin
        state_s      = state_r;
        remaining_s  = remaining_r;
        exact_s      = exact_r;
        cough_s      = cough_r;
        short_s      = short_r;
        q_s          = q_r;
        d_s          = d_r;
        n_s          = n_r;
        coin_valid_s = 1'b0;
        coin_s       = COIN_NONE;

        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    exact_s     = 1'b0;
                    cough_s     = 1'b0;
                    short_s     = 1'b0;
                    remaining_s = '0;
                    if (bus.paid < bus.cost) begin
                        cough_s = 1'b1;
                        state_s = DONE;
                    end else if (bus.paid == bus.cost) begin
                        exact_s = 1'b1;
                        state_s = DONE;
                    end else begin
                        remaining_s = change_s;
                        // An empty-handed dispense is resolved right away so
                        // the result arrives as quickly as the other no-coin cases.
                        if (idle_pick_s != COIN_NONE) begin
                            state_s = DISPENSE;
                        end else begin
                            short_s = 1'b1;
                            state_s = DONE;
                        end
                    end
                end else begin
`ifdef CHANGE_RELOAD_EN
                    if (bus.reload) begin
                        q_s = sat_add(q_r, bus.q_add);
                        d_s = sat_add(d_r, bus.d_add);
                        n_s = sat_add(n_r, bus.n_add);
                    end else begin
                        q_s = q_r;
                        d_s = d_r;
                        n_s = n_r;
                    end
`else
                    state_s = IDLE;
`endif
                end
            end

            DISPENSE: begin
                if (remaining_r == '0) begin
                    state_s = DONE;
                end else if (disp_pick_s != COIN_NONE) begin
                    coin_valid_s = 1'b1;
                    coin_s       = disp_pick_s;
                    remaining_s  = remaining_r - AMT_W'(disp_pick_s);
                    // pick_coin only selects a coin whose counter is non-zero,
                    // so these decrements cannot wrap.
                    case (disp_pick_s)
                        COIN_Q:  q_s = q_r - CNT_W'(1);
                        COIN_D:  d_s = d_r - CNT_W'(1);
                        COIN_N:  n_s = n_r - CNT_W'(1);
                        default: q_s = q_r;
                    endcase
                    if (remaining_s == '0) begin
                        state_s = DONE;
                    end else begin
                        state_s = DISPENSE;
                    end
                end else begin
                    short_s = 1'b1;
                    state_s = DONE;
                end
            end

            DONE: begin
                state_s = IDLE;
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, result flags, owed amount and inventory registers.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state_r     <= IDLE;
            remaining_r <= '0;
            exact_r     <= 1'b0;
            cough_r     <= 1'b0;
            short_r     <= 1'b0;
            q_r         <= CNT_W'(INIT_Q);
            d_r         <= CNT_W'(INIT_D);
            n_r         <= CNT_W'(INIT_N);
        end else begin
            state_r     <= state_s;
            remaining_r <= remaining_s;
            exact_r     <= exact_s;
            cough_r     <= cough_s;
            short_r     <= short_s;
            q_r         <= q_s;
            d_r         <= d_s;
            n_r         <= n_s;
        end
    end

    assign bus.busy          = (state_r != IDLE);
    assign bus.done          = (state_r == DONE);
    assign bus.exact_amount  = exact_r;
    assign bus.cough_up_more = cough_r;
    assign bus.short_change  = short_r;
    assign bus.coin_valid    = coin_valid_s;
    assign bus.coin          = coin_s;
    assign bus.remaining     = remaining_r;
    assign bus.q_cnt         = q_r;
    assign bus.d_cnt         = d_r;
    assign bus.n_cnt         = n_r;

endmodule
